// File: rtl/debounce_pkg.sv
// Shared types and constants for the sync_debounce block.
// Optional edge counter is enabled with DEBOUNCE_EDGE_CNT_EN.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHECK_HI  = 2'b01,
        STABLE_HI = 2'b11,
        CHECK_LO  = 2'b10
    } deb_state_t;

    localparam int unsigned EDGE_CNT_W = 16;

    function automatic deb_state_t idle_state(input logic level);
        return level ? STABLE_HI : STABLE_LO;
    endfunction

endpackage

// File: rtl/debounce_edge_counter.sv
// Free-running wrapping counter of accepted rising edges.
// Instantiated by sync_debounce only with DEBOUNCE_EDGE_CNT_EN.
module debounce_edge_counter
    import debounce_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    output logic [EDGE_CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + EDGE_CNT_W'(1);
        end
    end

endmodule

// File: rtl/sync_debounce.sv
// Second-stage synchroniser plus counting debouncer with edge strobes.
// Define DEBOUNCE_EDGE_CNT_EN to add the edge_count output.
module sync_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic data_in,
    output logic data_out,
    output logic rise_pulse,
`ifdef DEBOUNCE_EDGE_CNT_EN
    output logic fall_pulse,
    output logic [EDGE_CNT_W-1:0] edge_count
`else
    output logic fall_pulse
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam deb_state_t RST_STATE = idle_state(RESET_LEVEL);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES out of range");
    end

    logic             sync_q;
    deb_state_t       state;
    deb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             out_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= RESET_LEVEL;
        end else begin
            sync_q <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_STATE;
            cnt        <= '0;
            data_out   <= RESET_LEVEL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            data_out   <= out_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end

    // cnt counts samples already matching the candidate level
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = data_out;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        unique case (state)
            STABLE_LO: begin
                if (sync_q) begin
                    state_nxt = CHECK_HI;
                    cnt_nxt   = CNT_ONE;
                end
            end
            CHECK_HI: begin
                if (!sync_q) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                    out_nxt   = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!sync_q) begin
                    state_nxt = CHECK_LO;
                    cnt_nxt   = CNT_ONE;
                end
            end
            CHECK_LO: begin
                if (sync_q) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                    out_nxt   = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = RST_STATE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef DEBOUNCE_EDGE_CNT_EN
    debounce_edge_counter u_edge_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rise_pulse),
        .count (edge_count)
    );
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Self-checking bench: vector table, corner sequences, random vs model.
// Exercises the edge counter when DEBOUNCE_EDGE_CNT_EN is defined.
module tb_sync_debounce;
    import debounce_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic data_in;
    logic data_out, rise_pulse, fall_pulse;
    logic din_hi;
    logic out_hi, rise_hi, fall_hi;
`ifdef DEBOUNCE_EDGE_CNT_EN
    logic [15:0] edge_count;
    logic [15:0] edge_count_hi;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_debounce #(.DEBOUNCE_CYCLES(N), .RESET_LEVEL(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_out   (data_out),
        .rise_pulse (rise_pulse),
`ifdef DEBOUNCE_EDGE_CNT_EN
        .fall_pulse (fall_pulse),
        .edge_count (edge_count)
`else
        .fall_pulse (fall_pulse)
`endif
    );

    sync_debounce #(.DEBOUNCE_CYCLES(N), .RESET_LEVEL(1'b1)) dut_hi (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (din_hi),
        .data_out   (out_hi),
        .rise_pulse (rise_hi),
`ifdef DEBOUNCE_EDGE_CNT_EN
        .fall_pulse (fall_hi),
        .edge_count (edge_count_hi)
`else
        .fall_pulse (fall_hi)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: count consecutive samples that disagree with the output
    int   m_run;
    logic m_sync, m_s, m_out, m_rise, m_fall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sync = 1'b0;
            m_out  = 1'b0;
            m_run  = 0;
            m_rise = 1'b0;
            m_fall = 1'b0;
        end else begin
            m_s    = m_sync;
            m_sync = data_in;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_s != m_out) begin
                m_run = m_run + 1;
                if (m_run == N) begin
                    m_out  = m_s;
                    m_run  = 0;
                    m_rise = m_s;
                    m_fall = ~m_s;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    typedef struct {
        logic din;
        logic out;
        logic rise;
        logic fall;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input int n, input logic d, input logic o,
                                input logic r, input logic f);
        vec_t v;
        v.din = d; v.out = o; v.rise = r; v.fall = f;
        for (int k = 0; k < n; k++) vt.push_back(v);
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        data_in = 1'b0;
        din_hi  = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_data_out", data_out, 1'b0);
        chk("rst_rise", rise_pulse, 1'b0);
        chk("rst_fall", fall_pulse, 1'b0);
        chk("rst_state", dut.state, STABLE_LO);
        chk("rst_cnt", dut.cnt, 0);
        chk("rst_sync", dut.sync_q, 1'b0);
        chk("rst_hi_out", out_hi, 1'b1);
        chk("rst_hi_state", dut_hi.state, STABLE_HI);
`ifdef DEBOUNCE_EDGE_CNT_EN
        chk("rst_edge_count", edge_count, 16'h0000);
`endif

        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            cyc();
            chk("hi_hold_out", out_hi, 1'b1);
            chk("hi_hold_pulse", {rise_hi, fall_hi}, 2'b00);
            chk("lo_idle_out", {data_out, rise_pulse, fall_pulse}, 3'b000);
        end

        add(4, 1, 0, 0, 0);
        add(1, 1, 1, 1, 0);
        add(2, 1, 1, 0, 0);
        add(4, 0, 1, 0, 0);
        add(1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0);
        add(3, 1, 0, 0, 0);
        add(5, 0, 0, 0, 0);
        add(3, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0);
        add(4, 1, 0, 0, 0);
        add(1, 1, 1, 1, 0);
        add(2, 1, 1, 0, 0);
        add(4, 0, 1, 0, 0);
        add(1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < vt.size(); i++) begin
            data_in = vt[i].din;
            cyc();
            chk($sformatf("vec%0d_out", i), data_out, vt[i].out);
            chk($sformatf("vec%0d_rise", i), rise_pulse, vt[i].rise);
            chk($sformatf("vec%0d_fall", i), fall_pulse, vt[i].fall);
            if (i == 20) chk("glitch_state", dut.state, STABLE_LO);
            if (i == 25) chk("restart_state", dut.state, STABLE_LO);
        end

        data_in = 1'b1;
        repeat (4) cyc();
        chk("mid_check_cnt", dut.cnt, 3);
        chk("mid_check_state", dut.state, CHECK_HI);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out", {data_out, rise_pulse, fall_pulse}, 3'b000);
        chk("async_rst_state", dut.state, STABLE_LO);
        chk("async_rst_cnt", dut.cnt, 0);
        data_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk("post_rst_quiet", {data_out, rise_pulse, fall_pulse}, 3'b000);
        end

`ifdef DEBOUNCE_EDGE_CNT_EN
        force dut.u_edge_cnt.count = 16'hFFFE;
        cyc();
        release dut.u_edge_cnt.count;
        cyc();
        chk("cnt_preload", edge_count, 16'hFFFE);
        data_in = 1'b1;
        repeat (7) cyc();
        chk("cnt_ffff", edge_count, 16'hFFFF);
        data_in = 1'b0;
        repeat (7) cyc();
        data_in = 1'b1;
        repeat (7) cyc();
        chk("cnt_wrap", edge_count, 16'h0000);
        data_in = 1'b0;
        repeat (7) cyc();
`endif

        for (int b = 0; b < 150; b++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            if (b == 75) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int k = 0; k < len; k++) begin
                data_in = lvl;
                cyc();
                chk("rand_out", data_out, m_out);
                chk("rand_pulses", {rise_pulse, fall_pulse}, {m_rise, m_fall});
                chk("rand_exclusive", rise_pulse & fall_pulse, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk (single clock) and rst_n (asynchronous, active-low).
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples required to accept a level change; legal range 2..65535.
REQ-003 The module SHALL have parameter RESET_LEVEL, default 1'b0: level of the sync stage and data_out during and after reset.
REQ-004 The module SHALL have port clk, input, 1 bit: the only clock; all state SHALL be posedge clk.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port data_in, input, 1 bit: the level registered once into the clk domain by the upstream cross-clock buffer.
REQ-007 The module SHALL have port data_out, output, 1 bit: the debounced stable level.
REQ-008 The module SHALL have port rise_pulse, output, 1 bit: a one-cycle strobe when data_out goes 0->1.
REQ-009 The module SHALL have port fall_pulse, output, 1 bit: a one-cycle strobe when data_out goes 1->0.
REQ-010 The module SHALL have port edge_count, output, 16 bits: accepted rising edges; the port SHALL be present only with DEBOUNCE_EDGE_CNT_EN.

Function
REQ-011 The module SHALL register data_in into sync_q every clk edge as a second synchroniser stage; the FSM SHALL read only sync_q.
REQ-012 The FSM SHALL have states STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
REQ-013 In STABLE_LO with sync_q=1, the FSM SHALL go to CHECK_HI with cnt=1; in STABLE_HI with sync_q=0, it SHALL go to CHECK_LO with cnt=1.
REQ-014 In CHECK_x, sync_q equal to the candidate SHALL increment cnt, and sync_q differing from the candidate SHALL return to the previous STABLE_x with cnt=0 and no output change.
REQ-015 On the edge where cnt would reach DEBOUNCE_CYCLES, the FSM SHALL enter the new STABLE_x, update data_out, assert the matching pulse for exactly one cycle, and clear cnt.
REQ-016 Latency SHALL be DEBOUNCE_CYCLES+1 clk edges from the first edge sampling the new data_in level to data_out changing.
REQ-017 cnt SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide, SHALL never exceed DEBOUNCE_CYCLES, and SHALL never wrap.
REQ-018 rise_pulse and fall_pulse SHALL never be asserted simultaneously, and no pulse SHALL occur without a data_out change.
REQ-019 A glitch on data_in shorter than DEBOUNCE_CYCLES sampled cycles SHALL cause no change on any output.
REQ-020 The FSM SHALL be registered, and data_out and the pulse outputs SHALL be driven from flops with no combinational path from data_in.

Reset
REQ-021 While rst_n=0, the module SHALL hold sync_q=RESET_LEVEL, data_out=RESET_LEVEL, state=STABLE_LO if RESET_LEVEL=0 else STABLE_HI, cnt=0, rise_pulse=0, fall_pulse=0, and edge_count=0.
REQ-022 Reset asserted mid-CHECK SHALL abort the check immediately, and no pulse SHALL follow deassertion unless data_in differs from RESET_LEVEL for the full debounce period afterwards.
REQ-023 Reset deassertion SHALL be taken synchronously by the surrounding design, and the block SHALL add no reset synchroniser.

Configuration
REQ-024 With macro DEBOUNCE_EDGE_CNT_EN defined, edge_count SHALL exist and increment by 1 on each rise_pulse, wrapping 16'hFFFF->16'h0000.
REQ-025 Without DEBOUNCE_EDGE_CNT_EN, the edge_count port and its register SHALL be absent, with all other behaviour identical.

Structure
REQ-026 Package debounce_pkg SHALL hold the state enum typedef (deb_state_t), the state encodings, and the constant EDGE_CNT_W=16.
REQ-027 Sub-module debounce_edge_counter (16-bit wrapping counter with inc/rst_n) SHALL be instantiated only under DEBOUNCE_EDGE_CNT_EN, and all other logic SHALL stay flat in sync_debounce.

Verification
REQ-028 With DEBOUNCE_CYCLES=4 and RESET_LEVEL=0, data_in raised before edge 0 and held SHALL give data_out=1 after edge 4, rise_pulse=1 for the single cycle after edge 4, and fall_pulse=0 throughout.
REQ-029 With DEBOUNCE_CYCLES=4, a 3-cycle high glitch on data_in SHALL leave data_out=0 with no pulses, and state SHALL return to STABLE_LO.
REQ-030 With DEBOUNCE_CYCLES=4, data_in pattern 1,1,1,0,1,1,1,1 SHALL restart the count at the 0 sample, and data_out SHALL rise only after the last four 1s plus one edge.
REQ-031 With RESET_LEVEL=1 and data_in=1 held through reset release, data_out SHALL stay 1 with no pulses for at least 20 cycles.
REQ-032 rst_n pulled low at cnt=3 of a CHECK_HI SHALL zero all outputs asynchronously, and a subsequent data_in=0 SHALL produce no pulse.
REQ-033 With DEBOUNCE_EDGE_CNT_EN defined, edge_count preloaded to 16'hFFFE via forced stimulus followed by 2 debounced rises SHALL read 16'hFFFF and then 16'h0000.
